// File: rtl/mem_req_arbiter.sv
// Two-master arbiter in front of a single memory port.
// An instruction-fetch master and a load/store master share one request/response
// bus. Only one transaction is in flight at a time. Data requests normally win,
// but a saturating counter guarantees the fetch side a grant after a bounded
// number of consecutive data grants. An outstanding fetch can be flushed: its
// bus handshake still completes, but the response is swallowed.
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        resetn,

    // Instruction fetch master
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    // Load/store master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    // Shared memory port
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    // The limit must fit the 4-bit counter and be at least one grant; an
    // out-of-range value is clamped rather than silently wrapping.
    localparam int LIMIT_INT =
        (STARVE_LIMIT < 1)  ? 1  :
        (STARVE_LIMIT > 15) ? 15 : STARVE_LIMIT;
    localparam logic [3:0] LIMIT = 4'(LIMIT_INT);

    // Instruction fetches are always aligned word reads.
    localparam logic [1:0] INST_SIZE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // Control state
    state_t      state_q,      state_d;
    owner_t      owner_q,      owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        discard_q,    discard_d;

    // Registered bus request fields, captured on the grant cycle only
    logic        bus_wr_q,    bus_wr_d;
    logic [1:0]  bus_size_q,  bus_size_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;

    // Arbitration and handshake qualifiers
    logic        inst_starved;
    logic        grant_inst;
    logic        grant_data;
    logic        in_req;
    logic        in_resp;
    logic        addr_hs;
    logic        data_hs;

    // Pick a winner while idle: data first, unless the fetch side has waited
    // through STARVE_LIMIT consecutive data grants.
    always_comb begin
        inst_starved = inst_req && (starve_cnt_q == LIMIT);
        grant_inst   = (state_q == ST_IDLE) && inst_req && (!data_req || inst_starved);
        grant_data   = (state_q == ST_IDLE) && data_req && !grant_inst;
    end

    // Transaction sequencing: grant -> address phase -> response phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_inst || grant_data) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_addr_ok) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the winner and its request fields; they stay frozen until the
    // next grant so late requester changes never reach the bus.
    always_comb begin
        owner_d     = owner_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        if (grant_inst) begin
            owner_d     = OWN_INST;
            bus_wr_d    = 1'b0;
            bus_size_d  = INST_SIZE;
            bus_addr_d  = inst_addr;
            bus_wdata_d = 32'h0;
            bus_wstrb_d = 4'h0;
        end else if (grant_data) begin
            owner_d     = OWN_DATA;
            bus_wr_d    = data_wr;
            bus_size_d  = data_size;
            bus_addr_d  = data_addr;
            bus_wdata_d = data_wdata;
            bus_wstrb_d = data_wstrb;
        end
    end

    // Count data grants that bypassed a waiting fetch; saturate at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_inst) begin
            starve_cnt_d = 4'd0;
        end else if (grant_data && inst_req && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // A flush of an outstanding fetch is remembered until the transaction
    // retires, so the response can be dropped even if it arrives much later.
    always_comb begin
        discard_d = discard_q;
        if (state_d == ST_IDLE) begin
            discard_d = 1'b0;
        end else if ((state_q != ST_IDLE) && (owner_q == OWN_INST) && inst_cancel) begin
            discard_d = 1'b1;
        end
    end

    // Handshake outputs; all forced low while reset is asserted so the
    // masters never see a stale accept or response.
    always_comb begin
        in_req  = resetn && (state_q == ST_REQ);
        in_resp = resetn && (state_q == ST_RESP);
        addr_hs = in_req && bus_addr_ok;
        data_hs = in_resp && bus_data_ok;

        bus_req      = in_req;
        inst_addr_ok = addr_hs && (owner_q == OWN_INST);
        data_addr_ok = addr_hs && (owner_q == OWN_DATA);
        // A cancel in the very cycle the response lands also suppresses it.
        inst_data_ok = data_hs && (owner_q == OWN_INST) && !discard_q && !inst_cancel;
        data_data_ok = data_hs && (owner_q == OWN_DATA);
        inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
        data_rdata   = data_data_ok ? bus_rdata : 32'h0;
    end

    // Bus field outputs come straight from their registers.
    always_comb begin
        bus_wr    = bus_wr_q;
        bus_size  = bus_size_q;
        bus_addr  = bus_addr_q;
        bus_wdata = bus_wdata_q;
        bus_wstrb = bus_wstrb_q;
    end

    // Control state register; reset abandons any transaction in flight.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            starve_cnt_q <= 4'd0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            discard_q    <= discard_d;
        end
    end

    // Bus request field registers, cleared on reset.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'b00;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'h0;
        end else begin
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed transactions against a transaction-level
// model that is compared with the DUT on every falling edge, plus literal
// expectations for the key scenarios.
module tb_mem_req_arbiter;

    localparam int LIMIT = 4;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        inst_cancel = 1'b0;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic [3:0]  data_wstrb = 4'h0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    mem_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .aclk(aclk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding transaction described by: busy, accepted by the bus,
    // belongs to fetch, response dropped; plus the count of data grants that
    // passed over a waiting fetch.
    bit          m_on = 0;
    bit          m_busy, m_acc, m_inst, m_drop;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;

    task automatic mdl_reset();
        m_busy = 0; m_acc = 0; m_inst = 1; m_drop = 0; m_streak = 0;
        m_addr = 0; m_wdata = 0; m_wr = 0; m_size = 0; m_wstrb = 0;
    endtask

    always @(negedge aclk) begin
        logic e_req, e_iaok, e_daok, e_idok, e_ddok, done, pick_inst;
        if (!m_on) begin
            if (!resetn) begin
                m_on = 1;
                mdl_reset();
            end
        end else begin
            e_req  = resetn && m_busy && !m_acc;
            e_iaok = e_req && m_inst && bus_addr_ok;
            e_daok = e_req && !m_inst && bus_addr_ok;
            done   = resetn && m_busy && m_acc && bus_data_ok;
            e_idok = done && m_inst && !m_drop && !inst_cancel;
            e_ddok = done && !m_inst;

            chk1("m_bus_req", bus_req, e_req);
            chk1("m_bus_wr", bus_wr, m_wr);
            chk("m_bus_size", 32'(bus_size), 32'(m_size));
            chk("m_bus_addr", bus_addr, m_addr);
            chk("m_bus_wdata", bus_wdata, m_wdata);
            chk("m_bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
            chk1("m_inst_addr_ok", inst_addr_ok, e_iaok);
            chk1("m_data_addr_ok", data_addr_ok, e_daok);
            chk1("m_inst_data_ok", inst_data_ok, e_idok);
            chk1("m_data_data_ok", data_data_ok, e_ddok);
            chk("m_inst_rdata", inst_rdata, e_idok ? bus_rdata : 32'h0);
            chk("m_data_rdata", data_rdata, e_ddok ? bus_rdata : 32'h0);

            // advance to the state after the coming rising edge
            if (!resetn) begin
                mdl_reset();
            end else if (m_busy) begin
                if (m_inst && inst_cancel) m_drop = 1;
                if (!m_acc) begin
                    if (bus_addr_ok) m_acc = 1;
                end else if (bus_data_ok) begin
                    m_busy = 0;
                    m_drop = 0;
                end
            end else if (inst_req || data_req) begin
                pick_inst = inst_req && (!data_req || m_streak >= LIMIT);
                m_busy = 1; m_acc = 0; m_drop = 0; m_inst = pick_inst;
                if (pick_inst) begin
                    m_streak = 0;
                    m_addr = inst_addr; m_wr = 0; m_size = 2'b10; m_wdata = 0; m_wstrb = 0;
                end else begin
                    if (inst_req) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
                    m_addr = data_addr; m_wr = data_wr; m_size = data_size;
                    m_wdata = data_wdata; m_wstrb = data_wstrb;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        iaok;
        logic        daok;
        logic        idok;
        logic        ddok;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } txn_t;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Wait for the address phase, accept it at once, answer the next cycle.
    task automatic serve(input logic [31:0] rdata, input bit keep, input bit cancel_on_resp,
                         output txn_t t);
        int n;
        t = '0;
        n = 0;
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        chk1("serve_bus_req_seen", bus_req, 1'b1);
        if (bus_req) begin
            t.addr = bus_addr; t.wr = bus_wr; t.size = bus_size;
            t.wdata = bus_wdata; t.wstrb = bus_wstrb;
            bus_addr_ok = 1'b1;
            @(negedge aclk);
            t.iaok = inst_addr_ok; t.daok = data_addr_ok;
            tick();
            bus_addr_ok = 1'b0;
            if (!keep) begin
                inst_req = 1'b0;
                data_req = 1'b0;
            end
            bus_data_ok = 1'b1;
            bus_rdata = rdata;
            if (cancel_on_resp) inst_cancel = 1'b1;
            @(negedge aclk);
            t.idok = inst_data_ok; t.ddok = data_data_ok;
            t.irdata = inst_rdata; t.drdata = data_rdata;
            tick();
            bus_data_ok = 1'b0;
            bus_rdata = 32'h0;
            if (cancel_on_resp) inst_cancel = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t        t;
        logic [5:0]  order;

        // ---- reset ----
        resetn = 1'b0;
        repeat (3) tick();
        @(negedge aclk);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk1("rst_data_data_ok", data_data_ok, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        // ---- single fetch ----
        inst_req = 1'b1; inst_addr = 32'h1C000000;
        serve(32'h02800C0C, 0, 0, t);
        chk("fetch_addr", t.addr, 32'h1C000000);
        chk1("fetch_wr", t.wr, 1'b0);
        chk("fetch_size", 32'(t.size), 32'h2);
        chk("fetch_wstrb", 32'(t.wstrb), 32'h0);
        chk1("fetch_addr_ok", t.iaok, 1'b1);
        chk1("fetch_data_ok", t.idok, 1'b1);
        chk("fetch_rdata", t.irdata, 32'h02800C0C);
        chk1("fetch_no_data_ok_other", t.ddok, 1'b0);

        // ---- stray responses while idle ----
        bus_data_ok = 1'b1; bus_rdata = 32'h55AA55AA;
        @(negedge aclk);
        chk1("idle_stray_inst_data_ok", inst_data_ok, 1'b0);
        chk1("idle_stray_data_data_ok", data_data_ok, 1'b0);
        tick();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        tick();

        // ---- simultaneous fetch and store: store first ----
        inst_req = 1'b1; inst_addr = 32'h1C000040;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10;
        data_addr = 32'h100; data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
        serve(32'h0, 1, 0, t);
        chk("both_first_addr", t.addr, 32'h100);
        chk1("both_first_wr", t.wr, 1'b1);
        chk("both_first_wdata", t.wdata, 32'hDEADBEEF);
        chk("both_first_wstrb", 32'(t.wstrb), 32'hF);
        chk1("both_first_daok", t.daok, 1'b1);
        chk1("both_first_ddok", t.ddok, 1'b1);
        data_req = 1'b0;
        serve(32'h13572468, 0, 0, t);
        chk("both_second_addr", t.addr, 32'h1C000040);
        chk1("both_second_idok", t.idok, 1'b1);
        tick();

        // ---- starvation: 4 data grants, then 1 fetch, then data again ----
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10;
        data_addr = 32'h200; data_wdata = 32'h0; data_wstrb = 4'h0;
        inst_req = 1'b1; inst_addr = 32'h1C000080;
        order = 6'b0;
        for (int i = 0; i < 6; i++) begin
            serve(32'h1000 + 32'(i), 1, 0, t);
            order[i] = (t.addr == 32'h1C000080);
        end
        inst_req = 1'b0; data_req = 1'b0;
        chk("starve_grant_order", 32'(order), 32'h10);
        tick();

        // ---- cancel during response phase ----
        inst_req = 1'b1; inst_addr = 32'h1C000100;
        tick();
        chk1("cancel_bus_req", bus_req, 1'b1);
        bus_addr_ok = 1'b1;
        @(negedge aclk);
        chk1("cancel_addr_ok", inst_addr_ok, 1'b1);
        tick();
        bus_addr_ok = 1'b0; inst_req = 1'b0; inst_cancel = 1'b1;
        tick();
        inst_cancel = 1'b0;
        tick();
        bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge aclk);
        chk1("cancel_data_ok_suppressed", inst_data_ok, 1'b0);
        chk("cancel_rdata_zero", inst_rdata, 32'h0);
        tick();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        chk1("cancel_idle_after", bus_req, 1'b0);
        inst_req = 1'b1; inst_addr = 32'h1C000104;
        serve(32'h11112222, 0, 0, t);
        chk1("cancel_next_fetch_ok", t.idok, 1'b1);
        chk("cancel_next_fetch_rdata", t.irdata, 32'h11112222);

        // ---- cancel coincident with the response ----
        inst_req = 1'b1; inst_addr = 32'h1C000108;
        serve(32'h33334444, 0, 1, t);
        chk1("cancel_coincident_idok", t.idok, 1'b0);

        // ---- cancel while idle has no effect ----
        inst_req = 1'b1; inst_addr = 32'h1C00010C; inst_cancel = 1'b1;
        tick();
        inst_cancel = 1'b0;
        serve(32'h55556666, 0, 0, t);
        chk1("cancel_idle_no_effect", t.idok, 1'b1);

        // ---- cancel never affects a data transaction ----
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h204; inst_cancel = 1'b1;
        serve(32'h77778888, 0, 0, t);
        inst_cancel = 1'b0;
        chk1("cancel_data_unaffected", t.ddok, 1'b1);
        chk("cancel_data_rdata", t.drdata, 32'h77778888);

        // ---- bus stall, requester changes and stray response in REQ ----
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'b01;
        data_addr = 32'h300; data_wdata = 32'h12345678; data_wstrb = 4'b0011;
        tick();
        for (int i = 0; i < 5; i++) begin
            data_req = 1'b0;
            data_addr = 32'h400 + 32'(i);
            data_wdata = 32'(i);
            bus_data_ok = (i == 2);
            @(negedge aclk);
            chk1("stall_bus_req", bus_req, 1'b1);
            chk("stall_bus_addr", bus_addr, 32'h300);
            chk("stall_bus_wdata", bus_wdata, 32'h12345678);
            chk("stall_bus_wstrb", 32'(bus_wstrb), 32'h3);
            chk1("stall_no_addr_ok", data_addr_ok, 1'b0);
            chk1("stall_no_data_ok", data_data_ok, 1'b0);
            tick();
        end
        bus_data_ok = 1'b0;
        serve(32'h0, 0, 0, t);
        chk("stall_final_addr", t.addr, 32'h300);
        chk1("stall_final_daok", t.daok, 1'b1);
        chk1("stall_final_ddok", t.ddok, 1'b1);

        // ---- reset in response phase, then a stray response ----
        inst_req = 1'b1; inst_addr = 32'h1C000200;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        resetn = 1'b0;
        @(negedge aclk);
        chk1("rst_resp_bus_req", bus_req, 1'b0);
        chk1("rst_resp_inst_data_ok", inst_data_ok, 1'b0);
        tick();
        resetn = 1'b1;
        bus_data_ok = 1'b1; bus_rdata = 32'hBADBAD00;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            chk1("post_rst_inst_data_ok", inst_data_ok, 1'b0);
            chk1("post_rst_data_data_ok", data_data_ok, 1'b0);
            chk("post_rst_inst_rdata", inst_rdata, 32'h0);
            chk1("post_rst_bus_req", bus_req, 1'b0);
            chk("post_rst_bus_addr", bus_addr, 32'h0);
            tick();
        end
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        inst_req = 1'b1; inst_addr = 32'h1C000300;
        serve(32'h9ABCDEF0, 0, 0, t);
        chk1("post_rst_fetch_ok", t.idok, 1'b1);
        chk("post_rst_fetch_rdata", t.irdata, 32'h9ABCDEF0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
